// File: rtl/sap_xbar_varlat_n_to_one.sv
// N-to-1 OBI crossbar: arbitrates several OBI masters onto one slave port and returns
// each response to its issuer. Define SAP_XBAR_N21_FIXED_PRIO_EN for fixed priority.
module sap_xbar_varlat_n_to_one #(
  parameter int unsigned XBAR_NMASTER    = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter type obi_req_t = struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  },
  parameter type obi_resp_t = struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  }
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  master_req_i  [XBAR_NMASTER],
  output obi_resp_t master_resp_o [XBAR_NMASTER],
  output obi_req_t  slave_req_o,
  input  obi_resp_t slave_resp_i
);

  localparam int unsigned IDW = $clog2(XBAR_NMASTER);
  localparam int unsigned PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {FREE, LOCKED} arb_state_e;

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] lock_idx_q, lock_idx_d;
  logic [IDW-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] rr_base;
  logic           win_valid;
  logic           full;
  logic           push;
  logic           pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef SAP_XBAR_N21_FIXED_PRIO_EN
  assign rr_base = '0;
`else
  logic [IDW-1:0] rr_ptr_q;

  assign rr_base = rr_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (push) begin
      rr_ptr_q <= (winner == IDW'(XBAR_NMASTER - 1)) ? '0 : winner + IDW'(1);
    end
  end
`endif

  // Descending scan so the requester closest to rr_base is written last and wins.
  always_comb begin
    winner    = rr_base;
    win_valid = 1'b0;
    if (state_q == LOCKED) begin
      winner    = lock_idx_q;
      win_valid = master_req_i[lock_idx_q].req;
    end else begin
      for (int i = int'(XBAR_NMASTER) - 1; i >= 0; i--) begin
        if (master_req_i[IDW'((int'(rr_base) + i) % int'(XBAR_NMASTER))].req) begin
          winner    = IDW'((int'(rr_base) + i) % int'(XBAR_NMASTER));
          win_valid = 1'b1;
        end
      end
    end
  end

  // Full uses the registered count, so a same-cycle pop never unblocks a request.
  assign full = (count_q == CW'(MAX_OUTSTANDING));

  always_comb begin
    slave_req_o = '0;
    if (win_valid && !full && !rst_i) begin
      slave_req_o = master_req_i[winner];
    end
  end

  assign push = slave_req_o.req & slave_resp_i.gnt;
  assign pop  = slave_resp_i.rvalid & (count_q != '0) & ~rst_i;

  always_comb begin
    for (int m = 0; m < int'(XBAR_NMASTER); m++) begin
      master_resp_o[m]        = '0;
      master_resp_o[m].gnt    = push && (winner == IDW'(m));
      master_resp_o[m].rvalid = pop && (fifo_q[rd_ptr_q] == IDW'(m));
      master_resp_o[m].rdata  = slave_resp_i.rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      FREE: begin
        if (slave_req_o.req && !slave_resp_i.gnt) begin
          state_d    = LOCKED;
          lock_idx_d = winner;
        end
      end
      LOCKED: begin
        if (push) begin
          state_d = FREE;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= FREE;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= winner;
    end
  end

`ifndef SYNTHESIS
  // A response with nothing outstanding has no issuer and is dropped.
  a_rvalid_has_issuer: assert property (@(posedge clk_i) disable iff (rst_i)
    slave_resp_i.rvalid |-> (count_q != '0));
`endif

endmodule
